// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signals of the shared memory port
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic        i_err;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        MOV;
    logic        RW;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        MOC;
    logic [31:0] DataOut;
    logic        busy;

    modport master (
        input  i_req, i_addr, d_req, d_rw, d_addr, d_wdata, MOC, DataOut,
        output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
               MOV, RW, mem_addr, mem_wdata, busy
    );

    modport slave (
        output i_req, i_addr, d_req, d_rw, d_addr, d_wdata, MOC, DataOut,
        input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
               MOV, RW, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter for the single MOV/MOC memory port
module mem_port_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.master   bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_d_q, last_d_d;
    logic               gnt_d_q, gnt_d_d;
    logic               mis_q, mis_d;
    logic               mov_q, mov_d;
    logic               rw_q, rw_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        i_rdata_q, i_rdata_d;
    logic [31:0]        d_rdata_q, d_rdata_d;
    logic               i_ack_q, i_ack_d;
    logic               i_err_q, i_err_d;
    logic               d_ack_q, d_ack_d;
    logic               d_err_q, d_err_d;
    logic               busy_q, busy_d;
    logic               pick_d;
    logic [31:0]        sel_addr;

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        last_d_d  = last_d_q;
        gnt_d_d   = gnt_d_q;
        mis_d     = mis_q;
        mov_d     = mov_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        i_err_d   = 1'b0;
        d_ack_d   = 1'b0;
        d_err_d   = 1'b0;
        pick_d    = bus.d_req && (!bus.i_req || !last_d_q);
        sel_addr  = pick_d ? bus.d_addr : bus.i_addr;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    gnt_d_d = pick_d;
                    addr_d  = sel_addr;
                    rw_d    = pick_d ? bus.d_rw : 1'b1;
                    wdata_d = pick_d ? bus.d_wdata : 32'h0;
                    // A misaligned grant spends its XFER cycle with MOV low, then errors.
                    mis_d   = (sel_addr[1:0] != 2'b00);
                    mov_d   = (sel_addr[1:0] == 2'b00);
                    state_d = XFER;
                end
            end
            XFER: begin
                if (mis_q) begin
                    i_err_d  = !gnt_d_q;
                    d_err_d  = gnt_d_q;
                    last_d_d = gnt_d_q;
                    mis_d    = 1'b0;
                    state_d  = DONE;
                end else if (bus.MOC) begin
                    i_ack_d  = !gnt_d_q;
                    d_ack_d  = gnt_d_q;
                    if (rw_q && !gnt_d_q) i_rdata_d = bus.DataOut;
                    if (rw_q &&  gnt_d_q) d_rdata_d = bus.DataOut;
                    mov_d    = 1'b0;
                    last_d_d = gnt_d_q;
                    state_d  = DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
                    i_err_d  = !gnt_d_q;
                    d_err_d  = gnt_d_q;
                    mov_d    = 1'b0;
                    last_d_d = gnt_d_q;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_d_q  <= 1'b1;
            gnt_d_q   <= 1'b0;
            mis_q     <= 1'b0;
            mov_q     <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            i_err_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
            gnt_d_q   <= gnt_d_d;
            mis_q     <= mis_d;
            mov_q     <= mov_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            i_err_q   <= i_err_d;
            d_ack_q   <= d_ack_d;
            d_err_q   <= d_err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.MOV       = mov_q;
    assign bus.RW        = rw_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_err     = i_err_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam logic [31:0] K = 32'h8C01_0014;

    typedef struct {
        bit          port;
        bit          err;
        logic [31:0] rdata;
        logic [31:0] addr;
        bit          rw;
        logic [31:0] wdata;
        int          movc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   moc_wait = 0;
    int   mcnt = 0;
    int   mov_cnt = 0;
    logic [31:0] i_rdata_m = '0;
    logic [31:0] d_rdata_m = '0;
    exp_t exp_q[$];
    int   done_cyc[$];

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(15), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Memory model: raises MOC after moc_wait MOV cycles (never when negative).
    always @(negedge clk) begin
        if (!reset) begin
            mcnt = 0;
            bus.MOC = 1'b0;
            bus.DataOut = '0;
        end else if (bus.MOV) begin
            bus.MOC = (moc_wait >= 0) && (mcnt == moc_wait);
            bus.DataOut = bus.mem_addr ^ K;
            mcnt++;
        end else begin
            bus.MOC = 1'b0;
            bus.DataOut = '0;
            mcnt = 0;
        end
    end

    always @(negedge clk) begin
        int n;
        exp_t e;
        if (!reset) begin
            mov_cnt = 0;
        end else begin
            if (bus.MOV) begin
                if (mov_cnt == 0 && exp_q.size() > 0) begin
                    check_eq("mem_addr", bus.mem_addr, exp_q[0].addr);
                    check_eq("RW", {31'b0, bus.RW}, {31'b0, exp_q[0].rw});
                    if (!exp_q[0].rw) check_eq("mem_wdata", bus.mem_wdata, exp_q[0].wdata);
                end
                mov_cnt++;
            end
            n = int'(bus.i_ack) + int'(bus.i_err) + int'(bus.d_ack) + int'(bus.d_err);
            if (n > 0) begin
                check_eq("onehot", n, 1);
                check_eq("pending", {31'b0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("port", {31'b0, bus.d_ack | bus.d_err}, {31'b0, e.port});
                    check_eq("kind", {31'b0, bus.i_err | bus.d_err}, {31'b0, e.err});
                    check_eq(e.port ? "d_rdata" : "i_rdata", e.port ? bus.d_rdata : bus.i_rdata, e.rdata);
                    check_eq("mov_cycles", mov_cnt, e.movc);
                end
                mov_cnt = 0;
                done_cyc.push_back(cyc);
            end
        end
    end

    function automatic exp_t make_exp(input bit port, input bit rw, input logic [31:0] addr,
                                       input logic [31:0] wdata, input bit err, input int movc);
        exp_t e;
        e.port = port; e.rw = port ? rw : 1'b1; e.addr = addr; e.wdata = wdata;
        e.err = err; e.movc = movc;
        if (!err && e.rw) begin
            if (port) d_rdata_m = addr ^ K;
            else      i_rdata_m = addr ^ K;
        end
        e.rdata = port ? d_rdata_m : i_rdata_m;
        return e;
    endfunction

    task automatic run_xfer(input bit port, input bit rw, input logic [31:0] addr,
                            input logic [31:0] wdata, input int wait_m, input bit err,
                            input int movc, input int exp_lat, input string tag);
        int  lat;
        bit  done;
        exp_q.push_back(make_exp(port, rw, addr, wdata, err, movc));
        moc_wait = wait_m;
        if (port) begin
            bus.d_req = 1'b1; bus.d_rw = rw; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        lat = 0;
        done = 1'b0;
        while (!done && lat < 64) begin
            @(posedge clk); lat++;
            @(negedge clk);
            done = bus.i_ack | bus.i_err | bus.d_ack | bus.d_err;
        end
        check_eq({tag, "_done"}, {31'b0, done}, 1);
        check_eq({tag, "_latency"}, lat, exp_lat);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_tie(input int n, input logic [31:0] ia, input logic [31:0] da);
        int base;
        int seen;
        int t;
        base = done_cyc.size();
        for (int k = 0; k < n; k++)
            exp_q.push_back(make_exp(k[0], 1'b1, k[0] ? da : ia, 32'h0, 1'b0, 1));
        moc_wait = 0;
        bus.i_addr = ia; bus.d_addr = da; bus.d_rw = 1'b1;
        bus.i_req = 1'b1; bus.d_req = 1'b1;
        seen = 0; t = 0;
        while (seen < n && t < 100) begin
            @(negedge clk); t++;
            seen = done_cyc.size() - base;
        end
        check_eq("tie_count", seen, n);
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        for (int k = 1; k < seen; k++)
            check_eq("tie_gap", done_cyc[base + k] - done_cyc[base + k - 1], 3);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        bus.i_req = 1'b1; bus.d_req = 1'b1; bus.d_rw = 1'b1;
        bus.i_addr = 32'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check_eq("rst_ctl", {25'b0, bus.MOV, bus.RW, bus.busy, bus.i_ack, bus.i_err,
                                 bus.d_ack, bus.d_err}, 0);
            check_eq("rst_addr", bus.mem_addr | bus.mem_wdata, 0);
            check_eq("rst_rdata", bus.i_rdata | bus.d_rdata, 0);
        end
        reset = 1'b1;
        bus.i_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);

        run_tie(4, 32'h0000_0020, 32'h0000_0040);
        run_xfer(1'b0, 1'b1, 32'h0000_0010, 32'h0, 1, 1'b0, 2, 3, "fetch");
        check_eq("fetch_word", bus.i_rdata, 32'h8C01_0004);
        run_xfer(1'b1, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0, 1, 2, "write");
        run_xfer(1'b1, 1'b1, 32'h0000_0104, 32'h0, -1, 1'b1, 15, 16, "timeout");
        run_xfer(1'b1, 1'b1, 32'h0000_0108, 32'h0, 14, 1'b0, 15, 16, "moc_last");
        run_xfer(1'b1, 1'b1, 32'h0000_0102, 32'h0, 0, 1'b1, 0, 2, "misalign");
        run_xfer(1'b0, 1'b1, 32'h0000_0030, 32'h0, 0, 1'b0, 1, 2, "fetch2");

        moc_wait = -1;
        bus.d_rw = 1'b1; bus.d_addr = 32'h0000_0200; bus.d_req = 1'b1;
        for (int t = 0; t < 10 && !bus.MOV; t++) @(negedge clk);
        check_eq("midrst_mov", {31'b0, bus.MOV}, 1);
        reset = 1'b0;
        @(negedge clk);
        check_eq("midrst_out", {27'b0, bus.MOV, bus.i_ack, bus.i_err, bus.d_ack, bus.d_err}, 0);
        check_eq("midrst_busy", {31'b0, bus.busy}, 0);
        reset = 1'b1;
        bus.d_req = 1'b0;
        i_rdata_m = '0; d_rdata_m = '0;
        repeat (3) @(negedge clk);
        check_eq("midrst_quiet", {31'b0, bus.busy}, 0);

        run_tie(2, 32'h0000_0050, 32'h0000_0060);
        check_eq("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
